// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the dmem_arbiter and the single-port data memory.
// slave = arbiter side, master = requester/memory side.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_ready;
  logic                  req0_rvalid;
  logic [DATA_WIDTH-1:0] req0_rdata;

  logic                  req1_valid;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_ready;
  logic                  req1_rvalid;
  logic [DATA_WIDTH-1:0] req1_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, req0_rvalid, req0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, req0_rvalid, req0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for the single-port data memory (CPU port 0, loader port 1).
// Define DMEM_ARB_STATS_EN to add saturating grant/conflict counters.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
  output logic [15:0]       conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state;
  logic                  last_grant;
  logic                  owner;
  logic                  grant_sel;
  logic                  accept;
  logic                  both_valid;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    both_valid     = bus.req0_valid & bus.req1_valid;
    grant_sel      = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    accept         = (state == IDLE) & (bus.req0_valid | bus.req1_valid);
    bus.req0_ready = accept & ~grant_sel;
    bus.req1_ready = accept & grant_sel;
    sel_we         = grant_sel ? bus.req1_we    : bus.req0_we;
    sel_addr       = grant_sel ? bus.req1_addr  : bus.req0_addr;
    sel_wdata      = grant_sel ? bus.req1_wdata : bus.req0_wdata;
  end

  // Memory lines are loaded at the accept edge so they are valid throughout ISSUE;
  // mem_addr/mem_wdata double as the latched request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      owner           <= 1'b0;
      bus.mem_en      <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.req0_rvalid <= 1'b0;
      bus.req1_rvalid <= 1'b0;
      bus.req0_rdata  <= '0;
      bus.req1_rdata  <= '0;
    end else begin
      bus.req0_rvalid <= 1'b0;
      bus.req1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner         <= grant_sel;
            last_grant    <= grant_sel;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= sel_we;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          state      <= bus.mem_we ? IDLE : RESP;
        end
        RESP: begin
          if (owner) begin
            bus.req1_rdata  <= bus.mem_rdata;
            bus.req1_rvalid <= 1'b1;
          end else begin
            bus.req0_rdata  <= bus.mem_rdata;
            bus.req0_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
      conflict_cnt <= '0;
    end else if (accept) begin
      if (!grant_sel && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (grant_sel && gnt_cnt1 != '1)  gnt_cnt1 <= gnt_cnt1 + 16'd1;
      if (both_valid && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`else
  logic unused_both_valid;
  always_comb unused_both_valid = both_valid;
`endif

endmodule
